mul_booth_seq_ctrl: RTL and testbench

- Iterative radix-4 Booth multiplier controller for the TPU arithmetic utilities.
- Sequences a single Booth partial-product step (3-bit encode, ±1x/±2x/0 select, negate-carry) over the multiplier, one group per cycle, and accumulates into a 2*DW product.
- Used where area matters more than throughput: small MAC lanes and the scalar configuration path.
- Valid/ready handshake on input and output; one operation in flight.

---
 rtl/mul_booth_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_mul_booth_seq_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_booth_seq_ctrl.sv
// mul_booth_seq_ctrl: iterative radix-4 Booth multiplier controller.
// One Booth group is encoded and accumulated per cycle into a 2*DW+4 bit
// accumulator. The low 2*DW bits are the product. Valid/ready on both sides,
// one operation in flight.
// Optional build macro MUL_BOOTH_SEQ_SKIP_ZERO_EN: when defined, RUN ends
// early once every remaining multiplier group encodes to zero.
module mul_booth_seq_ctrl #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_a,
  input  logic [DW-1:0]   in_b,
  input  logic            in_signed,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] out_prod,
  output logic            busy
);

  localparam int NG = DW / 2 + 1;     // Booth groups per operation
  localparam int EW = DW + 2;         // extended operand width
  localparam int AW = 2 * DW + 4;     // accumulator width
  localparam int GW = $clog2(NG);     // group counter width

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [EW-1:0] a_q, a_d;
  logic [EW-1:0] b_q, b_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [GW-1:0] grp_q, grp_d;

  // Operand extension and per-group Booth datapath.
  logic [EW-1:0] a_ext, b_ext;
  logic [GW:0]   pp_shamt;
  logic [2:0]    enc;
  logic [AW-1:0] a_sx, mag, pp_ones, acc_step;
  logic          neg;
  logic          grp_last;
  logic          skip_now;

  assign a_ext    = {{2{in_signed & in_a[DW-1]}}, in_a};
  assign b_ext    = {{2{in_signed & in_b[DW-1]}}, in_b};
  assign pp_shamt = {grp_q, 1'b0};
  assign grp_last = (grp_q == GW'(NG - 1));

  // Booth encode of the current group and one accumulate step.
  always_comb begin
    // NOTE: every signal assigned in an always_comb gets a default up front,
    // so no path through the case can leave it unassigned and infer a latch.
    mag     = '0;
    neg     = 1'b0;
    enc     = 3'(({b_q, 1'b0}) >> pp_shamt);
    a_sx    = {{(AW - EW){a_q[EW-1]}}, a_q};
    case (enc)
      3'b001, 3'b010: mag = a_sx;
      3'b011:         mag = a_sx << 1;
      3'b100: begin   mag = a_sx << 1; neg = 1'b1; end
      3'b101, 3'b110: begin mag = a_sx; neg = 1'b1; end
      default:        mag = '0;
    endcase
    // Negation as ones-complement with the +1 carry-in at the group weight.
    pp_ones  = neg ? ~mag : mag;
    acc_step = acc_q + (pp_ones << pp_shamt) + (AW'(neg) << pp_shamt);
  end

`ifdef MUL_BOOTH_SEQ_SKIP_ZERO_EN
  // Remaining multiplier bits b[EW-1:2g+1] uniform means all later groups are 0.
  logic [EW-1:0] b_tail;
  always_comb begin
    b_tail   = $signed(b_q) >>> {grp_q, 1'b1};
    skip_now = (b_tail == '0) || (b_tail == '1);
  end
`else
  assign skip_now = 1'b0;
`endif

  // Next-state and register-update logic for IDLE -> RUN -> DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    grp_d   = grp_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a_ext;
          b_d     = b_ext;
          acc_d   = '0;
          grp_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_step;
        grp_d = grp_q + 1'b1;
        if (grp_last || skip_now) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      grp_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      grp_q   <= grp_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign out_prod  = acc_q[2*DW-1:0];

  // Guard bits above the product only absorb sign growth during accumulation.
  logic unused_acc_hi;
  assign unused_acc_hi = ^acc_q[AW-1:2*DW];

endmodule

// File: tb/tb_mul_booth_seq_ctrl.sv
// Testbench for mul_booth_seq_ctrl (DW=8): directed vectors plus a short
// randomized run, with a queue scoreboard checked by an output monitor.
module tb_mul_booth_seq_ctrl;

  localparam int DW = 8;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_a;
  logic [DW-1:0]   in_b;
  logic            in_signed;
  logic            out_valid;
  logic            out_ready;
  logic [2*DW-1:0] out_prod;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int popped = 0;
  logic [15:0] exp_q[$];

  mul_booth_seq_ctrl #(.DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_signed(in_signed),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_prod (out_prod),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL timeout %s", name);
  endtask

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic signed [15:0] sa, sb;
    if (s) begin
      sa = $signed({{8{a[7]}}, a});
      sb = $signed({{8{b[7]}}, b});
      return 16'(sa * sb);
    end
    return {8'b0, a} * {8'b0, b};
  endfunction

  // Monitor: every accepted product must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got 0x%0h with empty scoreboard", out_prod);
      end else begin
        check("prod", 32'(out_prod), 32'(exp_q.pop_front()));
        popped++;
      end
    end
  end

  // Present operands until accepted, then scramble them to show they are ignored.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input bit push, input logic [15:0] exp);
    int n;
    n = 0;
    @(posedge clk); #1;
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready) begin
      if (n == 50) begin
        timeout("in_ready");
        break;
      end
      n++;
      @(negedge clk);
    end
    if (push) begin
      exp_q.push_back(exp);
      pushed++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_signed = ~s;
  endtask

  // Count edges from the handshake edge until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 1;
    @(negedge clk);
    check("busy_in_run", {31'b0, busy}, 32'd1);
    check("in_ready_in_run", {31'b0, in_ready}, 32'd0);
    while (!out_valid) begin
      lat++;
      if (lat > 40) begin
        timeout("out_valid");
        break;
      end
      @(negedge clk);
    end
  endtask

  // Hold back-pressure for 'hold' cycles, then accept and confirm return to IDLE.
  task automatic release_out(input int hold, input logic [15:0] exp);
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", {31'b0, out_valid}, 32'd1);
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
      check("hold_prod", 32'(out_prod), 32'(exp));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("idle_in_ready", {31'b0, in_ready}, 32'd1);
    check("idle_out_valid", {31'b0, out_valid}, 32'd0);
    check("idle_busy", {31'b0, busy}, 32'd0);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] prod;
    int          lat_full;
    int          lat_skip;
    int          hold;
  } vec_t;

  vec_t vecs[5] = '{
    '{8'hFF, 8'hFF, 1'b0, 16'hFE01, 6, 6, 0},
    '{8'h80, 8'h80, 1'b1, 16'h4000, 6, 5, 0},
    '{8'hFF, 8'h05, 1'b1, 16'hFFFB, 6, 3, 0},
    '{8'h7F, 8'h80, 1'b1, 16'hC080, 6, 5, 0},
    '{8'h07, 8'h03, 1'b0, 16'h0015, 6, 3, 4}
  };

  initial begin
    int lat;
    logic [7:0]  ra, rb;
    logic        rs;
    logic [15:0] rexp;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_prod", 32'(out_prod), 32'd0);

    // Directed vectors with hand-computed products and latencies.
    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].s, 1'b1, vecs[i].prod);
      wait_valid(lat);
`ifdef MUL_BOOTH_SEQ_SKIP_ZERO_EN
      check("latency", 32'(lat), 32'(vecs[i].lat_skip));
`else
      check("latency", 32'(lat), 32'(vecs[i].lat_full));
`endif
      release_out(vecs[i].hold, vecs[i].prod);
    end

    // Reset during RUN at grp=2 aborts with no output.
    issue(8'h55, 8'h33, 1'b0, 1'b0, 16'h0000);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_prod", 32'(out_prod), 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_no_output", {31'b0, out_valid}, 32'd0);
    #1 out_ready = 1'b0;

    issue(8'h03, 8'h04, 1'b0, 1'b1, 16'h000C);
    wait_valid(lat);
    release_out(1, 16'h000C);

    // Randomized operands and handshake gaps against the arithmetic model.
    for (int k = 0; k < 200; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      rexp = model(ra, rb, rs);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      issue(ra, rb, rs, 1'b1, rexp);
      wait_valid(lat);
`ifdef MUL_BOOTH_SEQ_SKIP_ZERO_EN
      check("rand_latency_range", {31'b0, (lat >= 2 && lat <= 6)}, 32'd1);
`else
      check("rand_latency", 32'(lat), 32'd6);
`endif
      release_out(int'($urandom_range(0, 2)), rexp);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("pop_count", 32'(popped), 32'(pushed));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
